ro_arbiter: RTL and testbench
=============================

Name: ro_arbiter

Overview:
- Round-robin readout scheduler for the CHAN single-channel digitizer buffers.
- Tracks which channels have triggered, grants one channel at a time, and writes into the shared global FIFO:
  - one header word with channel number and bunch-crossing count;
  - then `howmany` data words pulled from the granted channel.
- Replaces the fixed-priority select/demux path. Applies FIFO backpressure without losing words.

Parameters:
- CHAN, 8, number of channels. Power of 2, ≥2.
- WIDTH, 16, data/FIFO word width. Must equal 1 + log2(CHAN) + BCW.
- SIZE, 8, width of the `howmany` word count.
- BCW, 12, width of the bunch-crossing counter input.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- TRIGGER  in  CHAN  per-channel trigger; level sampled every cycle.
- DAVAIL  in  CHAN  per-channel "buffer holds a complete event".
- howmany  in  SIZE  data words per event. Sampled at grant.
- BC  in  BCW  free-running bunch-crossing count.
- CH_DOUT  in  WIDTH*CHAN  concatenated channel outputs. Channel i occupies [i*WIDTH +: WIDTH].
- RD_REQUEST  out  CHAN  one-hot read strobe to the granted channel.
- FIFO_DIN  out  WIDTH  word to global FIFO.
- FIFO_WR_EN  out  1  FIFO write strobe.
- FIFO_FULL  in  1  global FIFO full.
- GRANT_CH  out  log2(CHAN)  currently/last granted channel.
- BUSY  out  1  high in any state except IDLE.

Behaviour:
- Reset values: RD_REQUEST=0, FIFO_WR_EN=0, FIFO_DIN=0, GRANT_CH=0, BUSY=0. Pending vector, skid register, counters and round-robin pointer all 0. State is IDLE.
- Pending flags:
  - pend[i] is set on any cycle TRIGGER[i]=1.
  - pend[i] is cleared in the DONE cycle for channel i.
  - If set and clear coincide, set wins.
- Eligibility: elig = pend & DAVAIL.
- Round-robin selection: the next grant is the lowest index ≥ (ptr+1) mod CHAN with elig=1, wrapping. After each grant, ptr ← granted channel. After reset ptr=CHAN-1, so channel 0 is searched first.
- FSM:
  - IDLE: if |elig, latch the grant into GRANT_CH, latch howmany into cnt, go to HDR. Else stay in IDLE.
  - HDR:
    - When FIFO_FULL=0: FIFO_WR_EN=1 with FIFO_DIN = {1'b0, GRANT_CH, BC}, where BC is the value in that cycle.
    - Next state is DATA, or DONE if cnt==0.
    - When FIFO_FULL=1: hold in HDR, no write.
  - DATA:
    - Channel read latency is 1 cycle: RD_REQUEST[g] at cycle t means CH_DOUT[g] is valid at t+1.
    - Issue RD_REQUEST[g] when reads_issued < cnt, skid is empty, and FIFO_FULL=0.
    - At t+1: if FIFO_FULL=0, write CH_DOUT[g] (FIFO_WR_EN=1). Otherwise capture it into the 1-entry skid.
    - While skid is full, no new reads are issued. Skid drains first, on the next cycle with FIFO_FULL=0.
    - Words are written in read order; none are lost or duplicated.
    - Leave DATA when writes_done == cnt. Max throughput is 1 word/cycle.
  - DONE: one cycle. Clear pend[g], return to IDLE. BUSY=0 only in IDLE.
- Counts are SIZE bits wide. Max event is 2^SIZE - 1 words; no wrap occurs within an event.
- A TRIGGER on the granted channel during its own service re-arms pend, so the channel is serviced again later.
- A DAVAIL drop mid-event is ignored; the event completes.
- Reset asserted mid-event aborts immediately to reset values. Partial FIFO contents are the FIFO owner's concern.
- Exactly one RD_REQUEST bit is high at most, and only in DATA.

Optional Feature:
- Macro: RO_ARB_DROPCNT_EN.
- Defined:
  - Adds output DROP_CNT[15:0] (reset 0).
  - Increments on each cycle where TRIGGER[i] rises (0→1 edge, per-bit edge detect) while pend[i] is already 1, or while i is granted and in service.
  - Increments by the number of such channels that cycle; saturates at 16'hFFFF.
- Undefined: no port, no edge-detect logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then TRIGGER[3] pulse, DAVAIL[3]=1, howmany=4, BC=12'h0A5 → FIFO gets 16'h30A5 then CH_DOUT[3] words d0..d3. 5 writes total, back in IDLE after DONE, pend[3]=0.
- TRIGGER=8'b1000_0101 together, all DAVAIL=1, howmany=2 → grant order ch0, ch2, ch7 (3 headers, 6 data). Then TRIGGER[0] again → ch0 granted next (wrap).
- howmany=0 on ch5 → exactly one write (header 16'h5xxx), no RD_REQUEST pulse.
- howmany=8, FIFO_FULL forced high for 3 cycles, once in HDR and once just after a read → header held. The in-flight word goes to skid then FIFO; the 8 data words arrive in order, with no loss or duplicate.
- Assert RST low mid-DATA → all outputs 0 in the same cycle (async). After release, channel 0 is searched first.
- (RO_ARB_DROPCNT_EN) Retrigger ch1 twice while it is pending → DROP_CNT=2. Force 65537 events → DROP_CNT=16'hFFFF.

Source files
------------

// File: rtl/ro_arbiter.sv
// ro_arbiter: round-robin readout scheduler for CHAN digitizer buffers.
// Grants one triggered channel at a time and writes a header word followed
// by `howmany` data words into the shared FIFO, with a 1-entry skid register
// so backpressure never loses an in-flight channel word.
// Optional build macro: RO_ARB_DROPCNT_EN adds the DROP_CNT retrigger counter.
module ro_arbiter #(
    parameter int CHAN  = 8,
    parameter int WIDTH = 16,
    parameter int SIZE  = 8,
    parameter int BCW   = 12
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [CHAN-1:0]         TRIGGER,
    input  logic [CHAN-1:0]         DAVAIL,
    input  logic [SIZE-1:0]         howmany,
    input  logic [BCW-1:0]          BC,
    input  logic [WIDTH*CHAN-1:0]   CH_DOUT,
    output logic [CHAN-1:0]         RD_REQUEST,
    output logic [WIDTH-1:0]        FIFO_DIN,
    output logic                    FIFO_WR_EN,
    input  logic                    FIFO_FULL,
    output logic [$clog2(CHAN)-1:0] GRANT_CH,
`ifdef RO_ARB_DROPCNT_EN
    output logic [15:0]             DROP_CNT,
`endif
    output logic                    BUSY
);

    localparam int LW = $clog2(CHAN);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t            state;
    logic [CHAN-1:0]   pend, elig, clr;
    logic [LW-1:0]     rr_next, sel, idx;
    logic [SIZE-1:0]   cnt, rd_cnt, wr_cnt;
    logic              inflight, skid_vld, rearm;
    logic [WIDTH-1:0]  skid, ch_word;
    logic              rd_go, hdr_wr, dat_wr, wr_last;

    assign elig    = pend & DAVAIL;
    assign ch_word = CH_DOUT[GRANT_CH*WIDTH +: WIDTH];
    assign BUSY    = (state != IDLE);

    // rr_next holds (last grant + 1); reset 0 means channel 0 is searched first
    always_comb begin
        sel = rr_next;
        idx = '0;
        for (int k = CHAN - 1; k >= 0; k--) begin
            idx = rr_next + LW'(k);
            if (elig[idx]) sel = idx;
        end
    end

    // read/write strobes; skid drains before any new read is issued
    always_comb begin
        rd_go   = (state == DATA) && (rd_cnt < cnt) && !skid_vld && !FIFO_FULL;
        hdr_wr  = (state == HDR) && !FIFO_FULL;
        dat_wr  = (state == DATA) && (inflight || skid_vld) && !FIFO_FULL;
        wr_last = dat_wr && ((wr_cnt + SIZE'(1)) == cnt);
        RD_REQUEST = '0;
        if (rd_go) RD_REQUEST[GRANT_CH] = 1'b1;
        FIFO_WR_EN = hdr_wr || dat_wr;
        FIFO_DIN   = '0;
        if (hdr_wr)      FIFO_DIN = WIDTH'({1'b0, GRANT_CH, BC});
        else if (dat_wr) FIFO_DIN = skid_vld ? skid : ch_word;
    end

    // pend clear in DONE is suppressed if the channel retriggered during service
    always_comb begin
        clr = '0;
        if (state == DONE && !rearm) clr[GRANT_CH] = 1'b1;
    end

    // pending flags: set wins over clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) pend <= '0;
        else      pend <= (pend & ~clr) | TRIGGER;
    end

    // scheduler FSM with word counters and skid register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            GRANT_CH <= '0;
            rr_next  <= '0;
            cnt      <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            inflight <= 1'b0;
            skid_vld <= 1'b0;
            skid     <= '0;
            rearm    <= 1'b0;
        end else begin
            inflight <= rd_go;
            if (inflight && FIFO_FULL) begin
                skid     <= ch_word;
                skid_vld <= 1'b1;
            end else if (skid_vld && !FIFO_FULL) begin
                skid_vld <= 1'b0;
            end
            case (state)
                IDLE: if (|elig) begin
                    GRANT_CH <= sel;
                    rr_next  <= sel + LW'(1);
                    cnt      <= howmany;
                    rd_cnt   <= '0;
                    wr_cnt   <= '0;
                    rearm    <= 1'b0;
                    state    <= HDR;
                end
                HDR: begin
                    if (TRIGGER[GRANT_CH]) rearm <= 1'b1;
                    if (!FIFO_FULL) state <= (cnt == '0) ? DONE : DATA;
                end
                DATA: begin
                    if (TRIGGER[GRANT_CH]) rearm <= 1'b1;
                    if (rd_go)   rd_cnt <= rd_cnt + SIZE'(1);
                    if (dat_wr)  wr_cnt <= wr_cnt + SIZE'(1);
                    if (wr_last) state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RO_ARB_DROPCNT_EN
    logic [CHAN-1:0] trig_q, rise, svc, drop_hit;
    logic [LW:0]     n_drop;
    logic [16:0]     drop_sum;

    assign rise     = TRIGGER & ~trig_q;
    assign drop_hit = rise & (pend | svc);
    assign drop_sum = {1'b0, DROP_CNT} + 17'(n_drop);

    // granted-channel mask while in service, and number of dropped retriggers
    always_comb begin
        svc = '0;
        if (state != IDLE) svc[GRANT_CH] = 1'b1;
        n_drop = '0;
        for (int i = 0; i < CHAN; i++) n_drop = n_drop + (LW+1)'(drop_hit[i]);
    end

    // saturating retrigger counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            trig_q   <= '0;
            DROP_CNT <= '0;
        end else begin
            trig_q   <= TRIGGER;
            DROP_CNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_ro_arbiter.sv
// Directed testbench for ro_arbiter (CHAN=8, WIDTH=16, SIZE=8, BCW=12).
module tb_ro_arbiter;

    logic         CLK, RST;
    logic [7:0]   TRIGGER, DAVAIL;
    logic [7:0]   howmany;
    logic [11:0]  BC;
    logic [127:0] CH_DOUT;
    logic [7:0]   RD_REQUEST;
    logic [15:0]  FIFO_DIN;
    logic         FIFO_WR_EN, FIFO_FULL;
    logic [2:0]   GRANT_CH;
    logic         BUSY;
`ifdef RO_ARB_DROPCNT_EN
    logic [15:0]  DROP_CNT;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] wq[$];
    int rd_pulses = 0;
    int rd_multi  = 0;
    int unsigned seq[8] = '{default: 0};

    ro_arbiter #(.CHAN(8), .WIDTH(16), .SIZE(8), .BCW(12)) dut (
        .CLK(CLK), .RST(RST), .TRIGGER(TRIGGER), .DAVAIL(DAVAIL),
        .howmany(howmany), .BC(BC), .CH_DOUT(CH_DOUT),
        .RD_REQUEST(RD_REQUEST), .FIFO_DIN(FIFO_DIN), .FIFO_WR_EN(FIFO_WR_EN),
        .FIFO_FULL(FIFO_FULL), .GRANT_CH(GRANT_CH),
`ifdef RO_ARB_DROPCNT_EN
        .DROP_CNT(DROP_CNT),
`endif
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // channel buffers: word valid one cycle after its read strobe
    always @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (RD_REQUEST[i]) begin
                CH_DOUT[i*16 +: 16] <= 16'hD000 + 16'(i * 256) + 16'(seq[i] % 256);
                seq[i] <= seq[i] + 1;
            end
        end
    end

    // FIFO side monitor
    always @(negedge CLK) begin
        if (FIFO_WR_EN) wq.push_back(FIFO_DIN);
        if (RD_REQUEST != 8'h00) rd_pulses <= rd_pulses + 1;
        if ($countones(RD_REQUEST) > 1) rd_multi <= rd_multi + 1;
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic apply_reset();
        RST = 1'b0; TRIGGER = '0; FIFO_FULL = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK); #1;
            if (wq.size() >= n && !BUSY) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; TRIGGER = '0; DAVAIL = '0; howmany = '0; BC = '0;
        FIFO_FULL = 1'b0; CH_DOUT = '0;
        #2 RST = 1'b0;
        #3;
        n_cmp++; if (RD_REQUEST !== 8'h00) begin n_bad++; $display("FAIL reset_rdreq: got %h want 00", RD_REQUEST); end
        n_cmp++; if (FIFO_WR_EN !== 1'b0)  begin n_bad++; $display("FAIL reset_wren: got %b want 0", FIFO_WR_EN); end
        n_cmp++; if (FIFO_DIN !== 16'h0)   begin n_bad++; $display("FAIL reset_din: got %h want 0000", FIFO_DIN); end
        n_cmp++; if (GRANT_CH !== 3'd0)    begin n_bad++; $display("FAIL reset_grant: got %0d want 0", GRANT_CH); end
        n_cmp++; if (BUSY !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        repeat (2) tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int s0; bit ok;
        wq.delete(); rd_pulses = 0; rd_multi = 0;
        s0 = seq[3];
        BC = 12'h0A5; howmany = 8'd4; DAVAIL = 8'h08;
        TRIGGER = 8'h08; tick(); TRIGGER = '0;
        wait_writes(5, ok);
        repeat (8) tick();
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got no completion want 5 writes"); end
        n_cmp++; if (wq.size() != 5) begin n_bad++; $display("FAIL single_count: got %0d want 5", wq.size()); end
        if (wq.size() == 5) begin
            n_cmp++; if (wq[0] !== 16'h30A5) begin n_bad++; $display("FAIL single_hdr: got %h want 30A5", wq[0]); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (wq[k+1] !== 16'hD300 + 16'((s0 + k) % 256)) begin
                    n_bad++; $display("FAIL single_data%0d: got %h want %h", k, wq[k+1], 16'hD300 + 16'((s0 + k) % 256));
                end
            end
        end
        n_cmp++; if (rd_pulses != 4) begin n_bad++; $display("FAIL single_reads: got %0d want 4", rd_pulses); end
        n_cmp++; if (rd_multi != 0)  begin n_bad++; $display("FAIL single_onehot: got %0d multi-hot want 0", rd_multi); end
        n_cmp++; if (GRANT_CH !== 3'd3) begin n_bad++; $display("FAIL single_grant: got %0d want 3", GRANT_CH); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_round_robin();
        int chs[3] = '{0, 2, 7};
        int s[3];
        logic [15:0] exp[$];
        bit ok;
        apply_reset();
        wq.delete();
        for (int c = 0; c < 3; c++) s[c] = seq[chs[c]];
        BC = 12'h123; howmany = 8'd2; DAVAIL = 8'hFF;
        TRIGGER = 8'b1000_0101; tick(); TRIGGER = '0;
        for (int c = 0; c < 3; c++) begin
            exp.push_back(16'(chs[c] * 4096) + 16'h0123);
            for (int k = 0; k < 2; k++) exp.push_back(16'hD000 + 16'(chs[c] * 256) + 16'((s[c] + k) % 256));
        end
        wait_writes(9, ok);
        repeat (6) tick();
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: got no completion want 9 writes"); end
        n_cmp++; if (wq.size() != 9) begin n_bad++; $display("FAIL rr_count: got %0d want 9", wq.size()); end
        for (int k = 0; k < 9 && k < wq.size(); k++) begin
            n_cmp++; if (wq[k] !== exp[k]) begin n_bad++; $display("FAIL rr_word%0d: got %h want %h", k, wq[k], exp[k]); end
        end
        // pointer now past ch7; ch0 must be next after wrap
        wq.delete();
        TRIGGER = 8'h01; tick(); TRIGGER = '0;
        wait_writes(3, ok);
        n_cmp++; if (!ok || wq.size() < 1 || wq[0] !== 16'h0123) begin
            n_bad++; $display("FAIL rr_wrap_hdr: got %h want 0123", (wq.size() > 0) ? wq[0] : 16'hxxxx);
        end
        n_cmp++; if (GRANT_CH !== 3'd0) begin n_bad++; $display("FAIL rr_wrap_grant: got %0d want 0", GRANT_CH); end
    endtask

    task automatic test_zero_len();
        bit ok;
        wq.delete(); rd_pulses = 0;
        BC = 12'h0F0; howmany = 8'd0; DAVAIL = 8'h20;
        TRIGGER = 8'h20; tick(); TRIGGER = '0;
        wait_writes(1, ok);
        repeat (6) tick();
        n_cmp++; if (!ok || wq.size() != 1) begin n_bad++; $display("FAIL zero_count: got %0d want 1", wq.size()); end
        n_cmp++; if (wq.size() < 1 || wq[0] !== 16'h50F0) begin
            n_bad++; $display("FAIL zero_hdr: got %h want 50F0", (wq.size() > 0) ? wq[0] : 16'hxxxx);
        end
        n_cmp++; if (rd_pulses != 0) begin n_bad++; $display("FAIL zero_reads: got %0d want 0", rd_pulses); end
    endtask

    task automatic test_backpressure();
        int s0; bit ok, seen;
        wq.delete(); rd_pulses = 0;
        s0 = seq[6];
        BC = 12'h066; howmany = 8'd8; DAVAIL = 8'h40;
        FIFO_FULL = 1'b1;
        TRIGGER = 8'h40; tick(); TRIGGER = '0;
        repeat (4) tick();
        // three HDR cycles have now passed under FULL
        n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL bp_hdr_held: got %0d writes want 0", wq.size()); end
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", BUSY); end
        FIFO_FULL = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (RD_REQUEST != 8'h00) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_first_read: got none want a read strobe"); end
        tick();
        FIFO_FULL = 1'b1;
        repeat (3) tick();
        n_cmp++; if (wq.size() != 1) begin n_bad++; $display("FAIL bp_data_held: got %0d writes want 1", wq.size()); end
        FIFO_FULL = 1'b0;
        wait_writes(9, ok);
        repeat (6) tick();
        n_cmp++; if (!ok || wq.size() != 9) begin n_bad++; $display("FAIL bp_count: got %0d want 9", wq.size()); end
        n_cmp++; if (wq.size() < 1 || wq[0] !== 16'h6066) begin
            n_bad++; $display("FAIL bp_hdr: got %h want 6066", (wq.size() > 0) ? wq[0] : 16'hxxxx);
        end
        for (int k = 0; k < 8 && k + 1 < wq.size(); k++) begin
            n_cmp++;
            if (wq[k+1] !== 16'hD600 + 16'((s0 + k) % 256)) begin
                n_bad++; $display("FAIL bp_data%0d: got %h want %h", k, wq[k+1], 16'hD600 + 16'((s0 + k) % 256));
            end
        end
        n_cmp++; if (rd_pulses != 8) begin n_bad++; $display("FAIL bp_reads: got %0d want 8", rd_pulses); end
    endtask

    task automatic test_async_reset();
        bit ok;
        wq.delete();
        BC = 12'h111; howmany = 8'd20; DAVAIL = 8'h02; FIFO_FULL = 1'b0;
        TRIGGER = 8'h02; tick(); TRIGGER = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (wq.size() >= 4) break;
        end
        n_cmp++; if (RD_REQUEST !== 8'h02) begin n_bad++; $display("FAIL ar_active: got %h want 02", RD_REQUEST); end
        #1 RST = 1'b0;
        #1;
        n_cmp++; if (RD_REQUEST !== 8'h00) begin n_bad++; $display("FAIL ar_rdreq: got %h want 00", RD_REQUEST); end
        n_cmp++; if (FIFO_WR_EN !== 1'b0)  begin n_bad++; $display("FAIL ar_wren: got %b want 0", FIFO_WR_EN); end
        n_cmp++; if (FIFO_DIN !== 16'h0)   begin n_bad++; $display("FAIL ar_din: got %h want 0000", FIFO_DIN); end
        n_cmp++; if (GRANT_CH !== 3'd0)    begin n_bad++; $display("FAIL ar_grant: got %0d want 0", GRANT_CH); end
        n_cmp++; if (BUSY !== 1'b0)        begin n_bad++; $display("FAIL ar_busy: got %b want 0", BUSY); end
        tick(); tick();
        RST = 1'b1;
        wq.delete();
        BC = 12'h222; howmany = 8'd1; DAVAIL = 8'h41;
        TRIGGER = 8'h41; tick(); TRIGGER = '0;
        wait_writes(4, ok);
        n_cmp++; if (!ok || wq.size() < 4 || wq[0] !== 16'h0222) begin
            n_bad++; $display("FAIL ar_first_ch0: got %h want 0222", (wq.size() > 0) ? wq[0] : 16'hxxxx);
        end
        n_cmp++; if (wq.size() < 3 || wq[2] !== 16'h6222) begin
            n_bad++; $display("FAIL ar_then_ch6: got %h want 6222", (wq.size() > 2) ? wq[2] : 16'hxxxx);
        end
    endtask

`ifdef RO_ARB_DROPCNT_EN
    task automatic test_dropcnt();
        apply_reset();
        DAVAIL = 8'h00;
        @(negedge CLK);
        n_cmp++; if (DROP_CNT !== 16'h0) begin n_bad++; $display("FAIL drop_reset: got %h want 0000", DROP_CNT); end
        tick();
        for (int r = 0; r < 3; r++) begin
            TRIGGER = 8'h02; tick(); TRIGGER = '0; tick();
        end
        @(negedge CLK);
        n_cmp++; if (DROP_CNT !== 16'd2) begin n_bad++; $display("FAIL drop_retrig: got %0d want 2", DROP_CNT); end
        tick();
        TRIGGER = 8'hFF; tick(); TRIGGER = '0; tick();
        @(negedge CLK);
        n_cmp++; if (DROP_CNT !== 16'd3) begin n_bad++; $display("FAIL drop_multi: got %0d want 3", DROP_CNT); end
        tick();
        for (int r = 0; r < 8200; r++) begin
            TRIGGER = 8'hFF; tick(); TRIGGER = '0; tick();
        end
        @(negedge CLK);
        n_cmp++; if (DROP_CNT !== 16'hFFFF) begin n_bad++; $display("FAIL drop_sat: got %h want FFFF", DROP_CNT); end
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_backpressure();
        test_async_reset();
`ifdef RO_ARB_DROPCNT_EN
        test_dropcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
